// File: rtl/core_pkg.sv
// core_pkg: shared types and constants for the RV32I multi-cycle sequencer.
//   state_e       : sequencer states
//   cls_t         : opcode class flags handed to the ALU
//   OP_*          : major opcode values (ir[6:0])
//   CAUSE_*       : trap_cause encodings
//   decode_class  : opcode -> class flags (at most one bit set)
//   is_legal_op   : opcode is one the sequencer knows how to step
package core_pkg;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEM       = 3'd3,
    WRITEBACK = 3'd4,
    HALT      = 3'd5,
    TRAP      = 3'd6
  } state_e;

  typedef struct packed {
    logic lui;
    logic i_type;
    logic i_load;
    logic branch;
    logic store;
  } cls_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'd0;
  localparam logic [1:0] CAUSE_IMEM_TO = 2'd1;
  localparam logic [1:0] CAUSE_DMEM_TO = 2'd2;

  function automatic cls_t decode_class(input logic [6:0] op);
    cls_t c;
    c        = '0;
    c.lui    = (op == OP_LUI);
    c.i_type = (op == OP_IMM);
    c.i_load = (op == OP_LOAD);
    c.branch = (op == OP_BRANCH);
    c.store  = (op == OP_STORE);
    return c;
  endfunction

  function automatic logic is_legal_op(input logic [6:0] op);
    return (op == OP_LUI) || (op == OP_IMM) || (op == OP_LOAD) ||
           (op == OP_STORE) || (op == OP_BRANCH) || (op == OP_R);
  endfunction

endpackage

// File: rtl/core_seq_timeout.sv
// core_seq_timeout: loadable down-counter with saturation at zero.
// Used as a wait budget: load the budget on entry to a wait, decrement
// on every cycle the wait continues, expired_o flags the last allowed cycle.
//   clk, rst_n  : clock, async active-low reset (counter -> RST_VAL)
//   clr_i       : force count to zero (highest priority)
//   ld_i        : load ld_val_i
//   ld_val_i    : load value
//   en_i        : decrement by one, saturating at zero
//   expired_o   : count is zero
module core_seq_timeout #(
  parameter int unsigned   W       = 8,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         ld_i,
  input  logic [W-1:0] ld_val_i,
  input  logic         en_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (ld_i)
      cnt_d = ld_val_i;
    else if (en_i && (cnt_q != '0))
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= RST_VAL;
    else
      cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/core_seq.sv
// core_seq: multi-cycle control sequencer for the RV32I core. Owns pc and ir,
// decodes the opcode class for the ALU and runs the imem/dmem handshakes.
//
// Optional build macro: CORE_SEQ_MULDIV_STALL_EN -- when defined, R-type
// instructions with funct7 == 7'b0000001 hold EXECUTE for MULDIV_CYCLES cycles.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   imem_req/imem_ack/imem_rdata    instruction fetch handshake at address pc
//   dmem_req/dmem_we/dmem_ack       data access handshake (address from ALU)
//   alu_pc_load/alu_new_pc          ALU branch decision and target
//   pc, ir                          program counter, instruction register
//   is_lui .. is_store              registered class flags to the ALU
//   rf_we, retire                   one-cycle strobes in WRITEBACK
//   halted, trap, trap_cause        sticky terminal status
//
// state     | meaning
// FETCH     | imem_req high until imem_ack, ir captured on ack
// DECODE    | class flags latched from ir[6:0]; illegal -> TRAP, SYSTEM -> HALT
// EXECUTE   | ALU works combinationally; loads/stores go to MEM
// MEM       | dmem_req high until dmem_ack
// WRITEBACK | rf_we/retire strobe, pc update, flags cleared
// HALT      | terminal after ECALL/EBREAK, left only by reset
// TRAP      | terminal after a fault, left only by reset
module core_seq #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT   = 16,
  parameter int unsigned MULDIV_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  input  logic        alu_pc_load,
  input  logic [31:0] alu_new_pc,
  output logic [31:0] pc,
  output logic [31:0] ir,
  output logic        is_lui,
  output logic        is_i_type,
  output logic        is_i_load_type,
  output logic        is_branch,
  output logic        is_store,
  output logic        rf_we,
  output logic        retire,
  output logic        halted,
  output logic        trap,
  output logic [1:0]  trap_cause
);
  import core_pkg::*;

  if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255 || MULDIV_CYCLES < 1) begin : g_param_check
    $error("core_seq: MEM_TIMEOUT or MULDIV_CYCLES out of range");
  end

  // Budget loaded on wait entry; the wait may last exactly MEM_TIMEOUT cycles.
  localparam logic [7:0] TO_LOAD = 8'(MEM_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  cls_t        cls_q, cls_d;
  logic        halted_q, halted_d;
  logic        trap_q, trap_d;
  logic [1:0]  cause_q, cause_d;

  logic        to_clr, to_ld, to_en, to_expired;
  logic [7:0]  to_ld_val;
  logic        writes_rd;

`ifdef CORE_SEQ_MULDIV_STALL_EN
  localparam logic [7:0] MD_LOAD = 8'(MULDIV_CYCLES - 1);
  logic md_q, md_d;
`endif

  core_seq_timeout #(
    .W       (8),
    .RST_VAL (TO_LOAD)
  ) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (to_clr),
    .ld_i      (to_ld),
    .ld_val_i  (to_ld_val),
    .en_i      (to_en),
    .expired_o (to_expired)
  );

  // R-type writes a register too, but has no ALU class flag of its own.
  assign writes_rd = cls_q.lui | cls_q.i_type | cls_q.i_load | (ir_q[6:0] == OP_R);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    cls_d     = cls_q;
    halted_d  = halted_q;
    trap_d    = trap_q;
    cause_d   = cause_q;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    rf_we     = 1'b0;
    retire    = 1'b0;
    to_clr    = 1'b0;
    to_ld     = 1'b0;
    to_ld_val = TO_LOAD;
    to_en     = 1'b0;
`ifdef CORE_SEQ_MULDIV_STALL_EN
    md_d      = md_q;
`endif

    case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = DECODE;
        end else if (to_expired) begin
          state_d = TRAP;
          trap_d  = 1'b1;
          cause_d = CAUSE_IMEM_TO;
        end else begin
          to_en = 1'b1;
        end
      end

      DECODE: begin
        cls_d = decode_class(ir_q[6:0]);
        if (ir_q[6:0] == OP_SYSTEM) begin
          state_d  = HALT;
          halted_d = 1'b1;
        end else if (is_legal_op(ir_q[6:0])) begin
          state_d = EXECUTE;
        end else begin
          state_d = TRAP;
          trap_d  = 1'b1;
          cause_d = CAUSE_ILLEGAL;
        end
`ifdef CORE_SEQ_MULDIV_STALL_EN
        // The wait counter is idle during EXECUTE, so it doubles as the stall timer.
        md_d = (ir_q[6:0] == OP_R) && (ir_q[31:25] == 7'b0000001);
        if (md_d) begin
          to_ld     = 1'b1;
          to_ld_val = MD_LOAD;
        end
`endif
      end

      EXECUTE: begin
`ifdef CORE_SEQ_MULDIV_STALL_EN
        if (md_q && !to_expired) begin
          to_en = 1'b1;
        end else
`endif
        begin
          if (cls_q.i_load || cls_q.store) begin
            state_d = MEM;
            to_ld   = 1'b1;
          end else begin
            state_d = WRITEBACK;
          end
        end
      end

      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = cls_q.store;
        if (dmem_ack) begin
          state_d = WRITEBACK;
        end else if (to_expired) begin
          state_d = TRAP;
          trap_d  = 1'b1;
          cause_d = CAUSE_DMEM_TO;
        end else begin
          to_en = 1'b1;
        end
      end

      WRITEBACK: begin
        rf_we   = writes_rd && (ir_q[11:7] != 5'd0);
        retire  = 1'b1;
        pc_d    = (cls_q.branch && alu_pc_load) ? alu_new_pc : pc_q + 32'd4;
        cls_d   = '0;
        state_d = FETCH;
        to_ld   = 1'b1;
`ifdef CORE_SEQ_MULDIV_STALL_EN
        md_d    = 1'b0;
`endif
      end

      HALT, TRAP: begin
        to_clr = 1'b1;
      end

      default: begin
        state_d = TRAP;
        trap_d  = 1'b1;
        cause_d = CAUSE_ILLEGAL;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      cls_q    <= '0;
      halted_q <= 1'b0;
      trap_q   <= 1'b0;
      cause_q  <= 2'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      cls_q    <= cls_d;
      halted_q <= halted_d;
      trap_q   <= trap_d;
      cause_q  <= cause_d;
    end
  end

`ifdef CORE_SEQ_MULDIV_STALL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      md_q <= 1'b0;
    else
      md_q <= md_d;
  end
`endif

  assign pc             = pc_q;
  assign ir             = ir_q;
  assign is_lui         = cls_q.lui;
  assign is_i_type      = cls_q.i_type;
  assign is_i_load_type = cls_q.i_load;
  assign is_branch      = cls_q.branch;
  assign is_store       = cls_q.store;
  assign halted         = halted_q;
  assign trap           = trap_q;
  assign trap_cause     = cause_q;

endmodule

// File: tb/tb_core_seq.sv
// Bench for core_seq: random instruction stream against a cycle-budget
// reference model, plus directed fault, halt and reset scenarios.
module tb_core_seq;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int          TO     = 16;
  localparam int          MDC    = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack;
  logic [31:0] imem_rdata, alu_new_pc, pc, ir;
  logic        alu_pc_load;
  logic        is_lui, is_i_type, is_i_load_type, is_branch, is_store;
  logic        rf_we, retire, halted, trap;
  logic [1:0]  trap_cause;

  always #5 clk = ~clk;

  core_seq #(
    .RESET_PC      (RST_PC),
    .MEM_TIMEOUT   (TO),
    .MULDIV_CYCLES (MDC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_ack       (dmem_ack),
    .alu_pc_load    (alu_pc_load),
    .alu_new_pc     (alu_new_pc),
    .pc             (pc),
    .ir             (ir),
    .is_lui         (is_lui),
    .is_i_type      (is_i_type),
    .is_i_load_type (is_i_load_type),
    .is_branch      (is_branch),
    .is_store       (is_store),
    .rf_we          (rf_we),
    .retire         (retire),
    .halted         (halted),
    .trap           (trap),
    .trap_cause     (trap_cause)
  );

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] exp_pc;
  int          cnt_ireq, cnt_dreq, cnt_ret, cnt_rfwe;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] flags_now();
    return {is_lui, is_i_type, is_i_load_type, is_branch, is_store};
  endfunction

  task automatic do_reset();
    rst_n       = 1'b0;
    imem_ack    = 1'b0;
    dmem_ack    = 1'b0;
    imem_rdata  = 32'h0;
    alu_pc_load = 1'b0;
    alu_new_pc  = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pc", pc, RST_PC);
    chk("rst_ir", ir, 32'h0);
    chk("rst_flags", 32'(flags_now()), 32'h0);
    chk("rst_status", {28'h0, halted, trap, trap_cause}, 32'h0);
    chk("rst_strobes", {29'h0, rf_we, retire, dmem_req}, 32'h0);
    rst_n  = 1'b1;
    exp_pc = RST_PC;
  endtask

  // One full instruction from first FETCH cycle through WRITEBACK.
  // fw = cycles before imem_ack, dw = cycles before dmem_ack.
  task automatic run_instr(input logic [31:0] instr, input int fw, input int dw,
                           input bit take, input logic [31:0] tgt);
    logic [6:0]  op;
    logic [4:0]  exp_flags, ex_flags;
    bit          is_mem, is_st, exp_wr, is_md;
    int          exp_lat, ex_cyc, mem_first, mem_last;
    int          n_ireq, n_dreq, n_we, n_ret, n_rfwe, ret_cyc;
    logic [31:0] exp_next;

    op = instr[6:0];
    exp_flags = {op == 7'b0110111, op == 7'b0010011, op == 7'b0000011,
                 op == 7'b1100011, op == 7'b0100011};
    is_mem  = (op == 7'b0000011) || (op == 7'b0100011);
    is_st   = (op == 7'b0100011);
    exp_wr  = ((op == 7'b0110111) || (op == 7'b0010011) || (op == 7'b0000011) ||
               (op == 7'b0110011)) && (instr[11:7] != 5'd0);
    is_md   = (op == 7'b0110011) && (instr[31:25] == 7'b0000001);
    ex_cyc  = fw + 3;
    exp_lat = fw + 4 + (is_mem ? dw + 1 : 0);
`ifdef CORE_SEQ_MULDIV_STALL_EN
    if (is_md) exp_lat += MDC - 1;
`endif
    mem_first = fw + 4;
    mem_last  = fw + 4 + dw;
    exp_next  = (op == 7'b1100011 && take) ? tgt : exp_pc + 32'd4;
    n_ireq = 0; n_dreq = 0; n_we = 0; n_ret = 0; n_rfwe = 0; ret_cyc = -1;
    ex_flags = '0;

    for (int c = 1; c <= exp_lat; c++) begin
      // Outside the fetch wait, imem_ack and rdata are noise the DUT must ignore.
      if (c <= fw + 1) imem_ack = (c == fw + 1);
      else             imem_ack = 1'($urandom_range(0, 1));
      imem_rdata  = (c == fw + 1) ? instr : $urandom;
      if (is_mem && c >= mem_first && c <= mem_last) dmem_ack = (c == mem_last);
      else if (is_mem && c == fw + 1)                dmem_ack = 1'b0;
      else                                           dmem_ack = 1'($urandom_range(0, 1));
      alu_pc_load = take;
      alu_new_pc  = tgt;
      @(negedge clk);
      n_ireq += int'(imem_req);
      n_dreq += int'(dmem_req);
      if (dmem_req && dmem_we) n_we++;
      if (c == ex_cyc) ex_flags = flags_now();
      if (retire) begin n_ret++; ret_cyc = c; end
      if (rf_we) n_rfwe++;
      @(posedge clk);
      #1;
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;

    chk("ireq_cycles", n_ireq, fw + 1);
    chk("dreq_cycles", n_dreq, is_mem ? dw + 1 : 0);
    chk("dmem_we_cycles", n_we, is_st ? dw + 1 : 0);
    chk("exec_flags", 32'(ex_flags), 32'(exp_flags));
    chk("retire_cycle", ret_cyc, exp_lat);
    chk("retire_count", n_ret, 1);
    chk("rf_we_count", n_rfwe, exp_wr ? 1 : 0);
    chk("pc_next", pc, exp_next);
    chk("ir_value", ir, instr);
    chk("flags_cleared", 32'(flags_now()), 32'h0);
    chk("no_fault", {30'h0, halted, trap}, 32'h0);
    exp_pc = exp_next;
    if (is_md) chk("md_seen", 32'(op), 32'h33);
  endtask

  // Run ncyc cycles with no acks except an optional fetch ack in cycle 1.
  task automatic run_stuck(input logic [31:0] instr, input bit fetch_ack, input int ncyc);
    cnt_ireq = 0; cnt_dreq = 0; cnt_ret = 0; cnt_rfwe = 0;
    for (int c = 1; c <= ncyc; c++) begin
      imem_ack   = fetch_ack && (c == 1);
      imem_rdata = instr;
      dmem_ack   = 1'b0;
      @(negedge clk);
      cnt_ireq += int'(imem_req);
      cnt_dreq += int'(dmem_req);
      cnt_ret  += int'(retire);
      cnt_rfwe += int'(rf_we);
      @(posedge clk);
      #1;
    end
    imem_ack = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 5);
    case (k)
      0: r[6:0] = 7'b0110111;
      1: r[6:0] = 7'b0010011;
      2: r[6:0] = 7'b0000011;
      3: r[6:0] = 7'b0100011;
      4: r[6:0] = 7'b1100011;
      default: begin
        r[6:0]   = 7'b0110011;
        r[31:25] = ($urandom_range(0, 1) == 1) ? 7'b0000001 : 7'b0000000;
      end
    endcase
    if ($urandom_range(0, 3) == 0) r[11:7] = 5'd0;
    return r;
  endfunction

  initial begin
    do_reset();

    // ADDI x1,x0,5 with zero-wait fetch: retire in cycle 4, pc 0x104
    run_instr(32'h00500093, 0, 0, 1'b0, 32'h0);
    // BEQ taken / not taken
    run_instr(32'h00000063, 0, 0, 1'b1, 32'h0000_0080);
    run_instr(32'h00000063, 0, 0, 1'b0, 32'h0000_0080);
    // SW with dmem_ack 3 cycles late: 4 request cycles, retire in cycle 8
    run_instr(32'h0020a023, 0, 3, 1'b0, 32'h0);
    // pc wraps past 2^32
    run_instr(32'h00000063, 1, 0, 1'b1, 32'hFFFF_FFFC);
    run_instr(32'h00500093, 0, 0, 1'b0, 32'h0);
    chk("pc_wrapped", pc, 32'h0);

    for (int i = 0; i < 40; i++)
      run_instr(rand_instr(), $urandom_range(0, 5), $urandom_range(0, 5),
                1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC);

    // imem timeout
    do_reset();
    run_stuck(32'h00500093, 1'b0, TO + 4);
    chk("imem_to_req_cycles", cnt_ireq, TO);
    chk("imem_to_trap", {30'h0, trap, imem_req}, 32'h2);
    chk("imem_to_cause", 32'(trap_cause), 32'd1);
    chk("imem_to_pc", pc, RST_PC);
    chk("imem_to_retire", cnt_ret, 0);

    // dmem timeout on a load
    do_reset();
    run_stuck(32'h0000a103, 1'b1, TO + 8);
    chk("dmem_to_ireq", cnt_ireq, 1);
    chk("dmem_to_req_cycles", cnt_dreq, TO);
    chk("dmem_to_trap", {30'h0, trap, dmem_req}, 32'h2);
    chk("dmem_to_cause", 32'(trap_cause), 32'd2);
    chk("dmem_to_noretire", cnt_ret + cnt_rfwe, 0);
    chk("dmem_to_pc", pc, RST_PC);

    // illegal opcode
    do_reset();
    run_stuck(32'h0000007F, 1'b1, 6);
    chk("illegal_trap", {30'h0, halted, trap}, 32'h1);
    chk("illegal_cause", 32'(trap_cause), 32'd0);
    chk("illegal_ireq", cnt_ireq, 1);
    chk("illegal_pc", pc, RST_PC);

    // EBREAK after one instruction
    do_reset();
    run_instr(32'h00500093, 0, 0, 1'b0, 32'h0);
    run_stuck(32'h00100073, 1'b1, 10);
    chk("halt_status", {30'h0, halted, trap}, 32'h2);
    chk("halt_ireq", cnt_ireq, 1);
    chk("halt_pc", pc, RST_PC + 32'd4);
    chk("halt_noretire", cnt_ret, 0);

    // reset while waiting in MEM
    do_reset();
    run_stuck(32'h0000a103, 1'b1, 3);
    chk("mem_wait_req", 32'(dmem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_dreq", 32'(dmem_req), 32'd0);
    chk("rst_mid_pc", pc, RST_PC);
    chk("rst_mid_strobes", {30'h0, rf_we, retire}, 32'h0);
    chk("rst_mid_flags", 32'(flags_now()), 32'h0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    exp_pc = RST_PC;
    run_instr(32'h0000a103, 2, 1, 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/core_seq.md
Name: core_seq

Overview:
Multi-cycle control sequencer for the RV32I core. It owns the PC and the instruction register and decodes the opcode class that drives the ALU's is_lui/is_i_type/is_i_load_type/is_branch/is_store inputs. It steps each instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK, and handles the req/ack handshakes to instruction and data memory. It sits between the memories, the register file and the ALU, and sequences that datapath.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
MEM_TIMEOUT, 16, cycles to wait for imem_ack/dmem_ack before trapping (valid range 1..255)
MULDIV_CYCLES, 4, EXECUTE hold cycles for mul/div (used only with the optional feature)

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  instruction fetch request at address pc
imem_ack  in  1  fetch data valid on imem_rdata
imem_rdata  in  32  fetched instruction
dmem_req  out  1  data access request; ALU supplies the address
dmem_we  out  1  1 = store, 0 = load; valid while dmem_req
dmem_ack  in  1  data access complete
alu_pc_load  in  1  ALU branch-taken flag
alu_new_pc  in  32  ALU branch target
pc  out  32  current PC
ir  out  32  instruction register
is_lui, is_i_type, is_i_load_type, is_branch, is_store  out  1 each  registered class flags to the ALU
rf_we  out  1  register-file write strobe, one cycle
retire  out  1  one-cycle pulse per completed instruction
halted  out  1  sticky; set by ECALL/EBREAK
trap  out  1  sticky; set on fault
trap_cause  out  2  0 illegal opcode, 1 imem timeout, 2 dmem timeout

Behaviour:
- Reset (async assert, sync-released use): state=FETCH, pc=RESET_PC, ir=0, all flags, strobes, halted, trap and trap_cause = 0.
- FETCH: imem_req=1 until imem_ack. On ack, ir<=imem_rdata and go to DECODE. A same-cycle ack is legal (single-cycle fetch).
- DECODE (1 cycle): latch the class flags from ir[6:0].
  - 0110111 -> is_lui
  - 0010011 -> is_i_type
  - 0000011 -> is_i_load_type
  - 0100011 -> is_store
  - 1100011 -> is_branch
  - 0110011 -> R-type (no flag set)
  - 1110011 -> HALT
  - any other opcode -> TRAP with cause 0
  - Exactly one flag or none is ever set.
- EXECUTE (1 cycle, ALU is combinational): loads and stores go to MEM; all others go to WRITEBACK.
- MEM: dmem_req=1 and dmem_we=is_store, held until dmem_ack, then WRITEBACK.
- WRITEBACK (1 cycle):
  - rf_we=1 for lui, I-type, R-type and load, but only when ir[11:7]!=0.
  - pc <= alu_new_pc if (is_branch && alu_pc_load), else pc+4 (mod 2^32, wraps silently).
  - retire=1, clear flags, next state FETCH.
- Timeout: a counter resets on entry to FETCH/MEM and increments each cycle without ack. At MEM_TIMEOUT, drop req and go to TRAP with cause 1 or 2.
- HALT, TRAP: terminal states, left only by reset. Requests, rf_we and retire stay 0; pc holds at the faulting/halting instruction. halted or trap is set on entry.
- A late ack arriving in a non-waiting state is ignored.
- Reset mid-handshake: req drops immediately. No retire or rf_we is generated for the aborted instruction.
- Instruction latency: 4 cycles (non-memory) or 5 cycles (memory), with zero-wait acks.

Optional Feature:
CORE_SEQ_MULDIV_STALL_EN
- Defined: EXECUTE holds for MULDIV_CYCLES cycles when R-type with funct7==7'b0000001.
- Undefined: mul/div take 1 cycle like every other op. MULDIV_CYCLES is ignored.

Decomposition:
- core_pkg: state enum (FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT, TRAP), opcode localparams, trap_cause constants.
- Sub-module core_seq_timeout: loadable saturating wait counter with clear, enable and expired output. Shared by the fetch and data waits.

Test Plan:
- Reset RESET_PC=32'h100, then fetch ADDI x1,x0,5 (32'h00500093) with immediate acks -> imem_req in cycle 1; is_i_type=1 in EXECUTE; rf_we and retire in cycle 4; pc=32'h104.
- BEQ with alu_pc_load=1, alu_new_pc=32'h80 -> pc=32'h80 after WRITEBACK, rf_we=0. Repeat with alu_pc_load=0 -> pc+4.
- SW with dmem_ack delayed 3 cycles -> dmem_req=1 and dmem_we=1 for 4 cycles, retire at cycle 8, rf_we=0.
- Withhold imem_ack for 16 cycles -> trap=1, trap_cause=1, imem_req=0, pc unchanged. Also check no retire.
- Opcode 7'b1111111 -> trap_cause=0. EBREAK (32'h00100073) -> halted=1, no further imem_req.
- Assert rst_n low while in MEM -> dmem_req drops asynchronously, pc=RESET_PC, no rf_we.
